// File: rtl/counter_ctrl.sv
// Run/pause/stop controller around an N-bit up-counter that stops at a
// terminal count latched when a run begins, with a one-cycle done pulse.
module counter_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic [1:0]   msbs,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] lim_q,   lim_d;
  logic         done_q,  done_d;

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lim_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          lim_d   = limit;
        end
      end

      // Priority inside a run: stop, then pause, then terminal count.
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (count_q == lim_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + N'(1);
        end
      end

      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = RUN;
          count_d = '0;
          lim_d   = limit;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign count = count_q;
  assign msbs  = count_q[N-1:N-2];
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;
  assign state = state_q;

endmodule
